// File: rtl/motor_ctrl_pkg.sv
// Shared state encoding for the motor power sequencer; debug decoders on the
// Motor side import this too.
package motor_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DEAD  = 3'd3,
    ST_ESTOP = 3'd4
  } ramp_state_e;

endpackage

// File: rtl/ramp_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks, never resynced
// by commands.
module ramp_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Slews the signed Motor power word toward a commanded target, with zero-power
// dead time on reversal, emergency stop and a command watchdog.
module motor_ramp_ctrl
  import motor_ctrl_pkg::*;
#(
  parameter int SIZE       = 16,
  parameter int TICK_DIV   = 100000,
  parameter int STEP       = 16,
  parameter int MAX_POWER  = 623,
  parameter int DEAD_TICKS = 20,
  parameter int WDOG_TICKS = 500
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  input  logic signed [SIZE-1:0] cmd_power,
  output logic                   cmd_ready,
  input  logic                   estop,
  output logic signed [SIZE-1:0] motorPower,
  output logic [STATE_W-1:0]     state,
  output logic                   at_target,
  output logic                   wdog_expired
);

  localparam int DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS + 1) : 1;
  localparam int WW = (WDOG_TICKS > 1) ? $clog2(WDOG_TICKS + 1) : 1;
  localparam logic [DW-1:0]          DEAD_LAST = DW'(DEAD_TICKS - 1);
  localparam logic [WW-1:0]          WDOG_LAST = WW'(WDOG_TICKS - 1);
  localparam logic signed [SIZE-1:0] MAXP      = SIZE'(MAX_POWER);
  localparam logic signed [SIZE-1:0] STEP_V    = SIZE'(STEP);
  localparam logic signed [SIZE:0]   STEP_S    = (SIZE+1)'(STEP);

  ramp_state_e           state_q, state_n;
  logic signed [SIZE-1:0] mp_q, mp_n, tgt_q, tgt_n;
  logic [DW-1:0]          dead_q, dead_n;
  logic [WW-1:0]          wdog_q, wdog_n;
  logic                   wexp_q, wexp_n;
  logic                   tick, accept, opposing;
  logic signed [SIZE-1:0] cmd_clamped, goal, mp_stepped;
  logic signed [SIZE:0]   diff;

  ramp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign cmd_ready    = rst && (state_q != ST_ESTOP) && !estop;
  assign accept       = cmd_valid && cmd_ready;
  assign motorPower   = mp_q;
  assign state        = state_q;
  assign at_target    = (mp_q == tgt_q);
  assign wdog_expired = wexp_q;

  always_comb begin
    cmd_clamped = cmd_power;
    if (cmd_power > MAXP)       cmd_clamped = MAXP;
    else if (cmd_power < -MAXP) cmd_clamped = -MAXP;
  end

  // While output and target disagree in sign, head for zero first so a
  // reversal always passes through the dead time.
  assign opposing = (mp_q != '0) && (tgt_q != '0) && (mp_q[SIZE-1] != tgt_q[SIZE-1]);
  assign goal     = opposing ? '0 : tgt_q;
  assign diff     = {goal[SIZE-1], goal} - {mp_q[SIZE-1], mp_q};

  always_comb begin
    mp_stepped = goal;
    if (diff > STEP_S)       mp_stepped = mp_q + STEP_V;
    else if (diff < -STEP_S) mp_stepped = mp_q - STEP_V;
  end

  always_comb begin
    state_n = state_q;
    mp_n    = mp_q;
    tgt_n   = tgt_q;
    dead_n  = dead_q;
    wdog_n  = wdog_q;
    wexp_n  = wexp_q;

    if (accept) begin
      tgt_n  = cmd_clamped;
      wdog_n = '0;
      wexp_n = 1'b0;
    end else if (tgt_q == '0) begin
      wdog_n = '0;
    end else if (tick) begin
      if (wdog_q == WDOG_LAST) begin
        wdog_n = '0;
        wexp_n = 1'b1;
        tgt_n  = '0;
      end else begin
        wdog_n = wdog_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: if (tgt_q != '0) state_n = ST_RAMP;
      ST_RAMP: begin
        if (tick) begin
          mp_n = mp_stepped;
          if (opposing) begin
            if (mp_stepped == '0) begin
              state_n = ST_DEAD;
              dead_n  = '0;
            end
          end else if (mp_stepped == tgt_q) begin
            state_n = (tgt_q == '0) ? ST_IDLE : ST_HOLD;
          end
        end
      end
      ST_HOLD: if (tgt_q != mp_q) state_n = ST_RAMP;
      ST_DEAD: begin
        if (tgt_q == '0) begin
          state_n = ST_IDLE;
        end else if (tick) begin
          if (dead_q == DEAD_LAST) begin
            dead_n  = '0;
            state_n = ST_RAMP;
          end else begin
            dead_n = dead_q + 1'b1;
          end
        end
      end
      ST_ESTOP: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase

    // Emergency stop overrides everything, including a same-cycle command.
    if (estop) begin
      state_n = ST_ESTOP;
      mp_n    = '0;
      tgt_n   = '0;
      dead_n  = '0;
      wdog_n  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mp_q    <= '0;
      tgt_q   <= '0;
      dead_q  <= '0;
      wdog_q  <= '0;
      wexp_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      mp_q    <= mp_n;
      tgt_q   <= tgt_n;
      dead_q  <= dead_n;
      wdog_q  <= wdog_n;
      wexp_q  <= wexp_n;
    end
  end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: directed tick sequences, a settle-to-target table,
// and randomized commands checked against slew/zero-crossing rules.
module tb_motor_ramp_ctrl;
  import motor_ctrl_pkg::*;

  localparam int SIZE = 16, TICK_DIV = 4, STEP = 10, MAXP = 100, DEAD = 3, WDOG = 20;

  logic clk = 1'b0, rst = 1'b0, cmd_valid = 1'b0, estop = 1'b0;
  logic signed [SIZE-1:0] cmd_power = '0;
  logic cmd_ready, at_target, wdog_expired;
  logic signed [SIZE-1:0] motorPower;
  logic [2:0] state;

  always #5 clk = ~clk;

  motor_ramp_ctrl #(
    .SIZE(SIZE), .TICK_DIV(TICK_DIV), .STEP(STEP), .MAX_POWER(MAXP),
    .DEAD_TICKS(DEAD), .WDOG_TICKS(WDOG)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_power(cmd_power),
    .cmd_ready(cmd_ready), .estop(estop), .motorPower(motorPower),
    .state(state), .at_target(at_target), .wdog_expired(wdog_expired)
  );

  typedef struct { int cmd; int exp_mp; int exp_st; } vec_t;
  vec_t vt[8];

  int passed = 0, total = 0;
  int tcnt = 0;
  bit last_tick = 0, last_estop = 0, inv_on = 0, rnd_on = 0, est_mode = 0;
  int prev_mp = 0, exp_t = 0;
  int exp1[4]  = '{10, 20, 30, 35};
  int exp2[10] = '{25, 15, 5, 0, 0, 0, 0, -10, -20, -25};
  int exp5[5]  = '{40, 30, 20, 10, 0};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int clampv(input int v);
    return (v > MAXP) ? MAXP : ((v < -MAXP) ? -MAXP : v);
  endfunction

  // One clock: model update before the edge, rule checks just after it.
  task automatic cyc();
    int d;
    #1;
    if (rnd_on) chk("cmd_ready", cmd_ready, int'(rst && !est_mode && !estop));
    if (estop) exp_t = 0;
    else if (!est_mode && cmd_valid) exp_t = clampv(int'(cmd_power));
    est_mode   = estop;
    last_tick  = (tcnt == TICK_DIV - 1);
    last_estop = estop;
    prev_mp    = int'(motorPower);
    @(posedge clk);
    tcnt = (tcnt == TICK_DIV - 1) ? 0 : tcnt + 1;
    #1;
    if (inv_on) begin
      d = int'(motorPower) - prev_mp;
      chk("range", int'(motorPower > MAXP || motorPower < -MAXP), 0);
      if (!last_estop && !last_tick) chk("still_off_tick", int'(motorPower), prev_mp);
      if (!last_estop && last_tick) chk("slew_le_step", int'(d <= STEP && d >= -STEP), 1);
      if (prev_mp != 0 && motorPower != 0)
        chk("no_zero_skip", int'((prev_mp < 0) == (motorPower < 0)), 1);
    end
  endtask

  task automatic wait_tick();
    for (int n = 0; n < TICK_DIV; n++) begin
      cyc();
      if (last_tick) break;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; cmd_valid = 1'b0; estop = 1'b0; cmd_power = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; tcnt = 0; exp_t = 0; est_mode = 0;
  endtask

  task automatic send(input int v);
    cmd_power = SIZE'(v); cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
  endtask

  // Re-issue the command periodically so the watchdog never fires while settling.
  task automatic settle(input int v, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      cmd_power = SIZE'(v);
      cmd_valid = (i % 32 == 0);
      cyc();
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{35, 35, 2};     vt[1] = '{-25, -25, 2};
    vt[2] = '{500, 100, 2};   vt[3] = '{-32768, -100, 2};
    vt[4] = '{0, 0, 0};       vt[5] = '{32767, 100, 2};
    vt[6] = '{60, 60, 2};     vt[7] = '{-7, -7, 2};

    do_reset();
    #1;
    chk("rst_mp", int'(motorPower), 0);
    chk("rst_state", int'(state), int'(ST_IDLE));
    chk("rst_at_target", int'(at_target), 1);
    chk("rst_wdog", int'(wdog_expired), 0);
    chk("rst_ready_after", int'(cmd_ready), 1);
    inv_on = 1;

    // Ramp up from idle
    send(35);
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      chk($sformatf("t1_tick%0d", i), int'(motorPower), exp1[i]);
    end
    chk("t1_state", int'(state), int'(ST_HOLD));
    chk("t1_at_target", int'(at_target), 1);

    // Reversal with dead time
    send(-25);
    for (int i = 0; i < 10; i++) begin
      wait_tick();
      chk($sformatf("t2_tick%0d", i), int'(motorPower), exp2[i]);
      if (i == 3) chk("t2_dead", int'(state), int'(ST_DEAD));
      if (i == 6) chk("t2_ramp_again", int'(state), int'(ST_RAMP));
    end
    chk("t2_hold", int'(state), int'(ST_HOLD));

    // Settle-to-target table, includes clamping
    foreach (vt[i]) begin
      settle(vt[i].cmd, 200);
      chk($sformatf("tbl%0d_mp", i), int'(motorPower), vt[i].exp_mp);
      chk($sformatf("tbl%0d_state", i), int'(state), vt[i].exp_st);
      chk($sformatf("tbl%0d_at_target", i), int'(at_target), 1);
    end

    // Emergency stop at +60 with a command pending
    settle(60, 200);
    chk("t4_pre", int'(motorPower), 60);
    estop = 1'b1; cmd_valid = 1'b1; cmd_power = 16'sd80;
    #1;
    chk("t4_ready_low", int'(cmd_ready), 0);
    cyc();
    chk("t4_mp_zero", int'(motorPower), 0);
    chk("t4_state", int'(state), int'(ST_ESTOP));
    cyc();
    estop = 1'b0; cmd_valid = 1'b0;
    #1;
    chk("t4_ready_in_estop", int'(cmd_ready), 0);
    cyc();
    chk("t4_idle", int'(state), int'(ST_IDLE));
    for (int i = 0; i < 3; i++) wait_tick();
    chk("t4_stay_zero", int'(motorPower), 0);
    chk("t4_ready_back", int'(cmd_ready), 1);

    // Watchdog expiry and clear
    do_reset();
    send(50);
    for (int t = 1; t <= 20; t++) begin
      wait_tick();
      if (t == 19) chk("t5_wdog_before", int'(wdog_expired), 0);
      if (t == 20) chk("t5_wdog_set", int'(wdog_expired), 1);
    end
    chk("t5_mp_at_expiry", int'(motorPower), 50);
    for (int i = 0; i < 5; i++) begin
      wait_tick();
      chk($sformatf("t5_down%0d", i), int'(motorPower), exp5[i]);
    end
    chk("t5_idle", int'(state), int'(ST_IDLE));
    send(20);
    chk("t5_wdog_clear", int'(wdog_expired), 0);

    // Async reset mid-ramp, then accept on a tick cycle
    do_reset();
    send(100);
    for (int i = 0; i < 4; i++) wait_tick();
    chk("t6_pre", int'(motorPower), 40);
    cyc();
    rst = 1'b0;
    #1;
    chk("t6_mp", int'(motorPower), 0);
    chk("t6_state", int'(state), int'(ST_IDLE));
    chk("t6_at_target", int'(at_target), 1);
    chk("t6_wdog", int'(wdog_expired), 0);
    chk("t6_ready", int'(cmd_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b1; tcnt = 0;
    send(50);
    wait_tick();
    chk("t6_first_step", int'(motorPower), 10);
    while (tcnt != TICK_DIV - 1) cyc();
    send(15);
    chk("t6_old_target_step", int'(motorPower), 20);
    wait_tick();
    chk("t6_new_target", int'(motorPower), 15);
    chk("t6_hold", int'(state), int'(ST_HOLD));

    // Randomized commands and stop pulses
    do_reset();
    rnd_on = 1;
    for (int r = 0; r < 25; r++) begin
      for (int c = 0; c < 60; c++) begin
        estop     = ($urandom_range(0, 29) == 0);
        cmd_valid = ($urandom_range(0, 5) == 0) || (c % 32 == 0);
        case ($urandom_range(0, 5))
          0:       cmd_power = -16'sd32768;
          1:       cmd_power = 16'sd32767;
          2:       cmd_power = '0;
          default: cmd_power = SIZE'(int'($urandom_range(0, 240)) - 120);
        endcase
        cyc();
      end
      estop = 1'b0;
      settle(exp_t, 200);
      chk($sformatf("rnd%0d_mp", r), int'(motorPower), exp_t);
      chk($sformatf("rnd%0d_at_target", r), int'(at_target), 1);
      chk($sformatf("rnd%0d_state", r), int'(state), (exp_t == 0) ? int'(ST_IDLE) : int'(ST_HOLD));
      chk($sformatf("rnd%0d_wdog", r), int'(wdog_expired), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
